// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 scan scheduler.
package hub75_pkg;

    // Scheduler states; FETCH is split into its read and wait cycles.
    typedef enum logic [2:0] {
        StIdle,
        StFetchRd,
        StFetchWait,
        StShiftLo,
        StShiftHi,
        StBlank,
        StLatch,
        StDisplay
    } state_e;

    // Bit positions of each colour lane within the registered RGB vector.
    localparam int unsigned LaneR1   = 5;
    localparam int unsigned LaneG1   = 4;
    localparam int unsigned LaneB1   = 3;
    localparam int unsigned LaneR2   = 2;
    localparam int unsigned LaneG2   = 1;
    localparam int unsigned LaneB2   = 0;
    localparam int unsigned NumLanes = 6;

    // Width of the A..E row address pins.
    localparam int unsigned RowAddrW = 5;

    // Bits needed to index n items; never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hub75_plane_timer.sv
// Loadable down-counter timing DISPLAY and BLANK phases.
module hub75_plane_timer #(
    parameter int unsigned CntW = 11
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic [CntW-1:0] value_i,
    input  logic            en_i,
    output logic            done_o,
    output logic            done_next_o
);

    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Load takes priority; otherwise count down while enabled, stopping at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // done_o marks the last counted cycle; done_next_o lets callers register a pulse for it.
    assign done_o      = (cnt_q == CntOne);
    assign done_next_o = (cnt_d == CntOne);

endmodule

// File: rtl/hub75_scan_scheduler.sv
// HUB75 binary-code-modulation scan scheduler: per row and bit plane it fetches pixels,
// shifts them out, latches and displays for BASE_ON<<plane cycles.
// Optional feature: define HUB75_DEADTIME_EN to insert a DEADTIME-cycle BLANK before LATCH.
module hub75_scan_scheduler
    import hub75_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH = 32,
    parameter int unsigned SCREEN_DEPTH = 16,
    parameter int unsigned BIT_DEPTH    = 4,
    parameter int unsigned BASE_ON      = 8,
    parameter int unsigned DEADTIME     = 2,
    localparam int unsigned ROW_W       = width_of(SCREEN_DEPTH / 2),
    localparam int unsigned COL_W       = width_of(SCREEN_WIDTH)
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     enable_in,
    output logic                     rd_en_out,
    output logic [ROW_W+COL_W-1:0]   rd_addr_out,
    input  logic [6*BIT_DEPTH-1:0]   rd_data_in,
    output logic                     R1_data,
    output logic                     G1_data,
    output logic                     B1_data,
    output logic                     R2_data,
    output logic                     G2_data,
    output logic                     B2_data,
    output logic                     A,
    output logic                     B,
    output logic                     C,
    output logic                     D,
    output logic                     E,
    output logic                     clk_out,
    output logic                     LAT,
    output logic                     OE_N,
    output logic                     frame_done
);

    localparam int unsigned ROWS     = SCREEN_DEPTH / 2;
    localparam int unsigned PLANE_W  = width_of(BIT_DEPTH);
    localparam int unsigned MaxOn    = BASE_ON << (BIT_DEPTH - 1);
    localparam int unsigned MaxLoad  = (MaxOn > DEADTIME) ? MaxOn : DEADTIME;
    localparam int unsigned TMR_W    = width_of(MaxLoad) + 1;

    localparam logic [COL_W-1:0]   ColLast   = COL_W'(SCREEN_WIDTH - 1);
    localparam logic [COL_W-1:0]   ColOne    = COL_W'(1);
    localparam logic [ROW_W-1:0]   RowLast   = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]   RowOne    = ROW_W'(1);
    localparam logic [PLANE_W-1:0] PlaneLast = PLANE_W'(BIT_DEPTH - 1);
    localparam logic [PLANE_W-1:0] PlaneOne  = PLANE_W'(1);

    state_e state_q, state_d;

    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [PLANE_W-1:0]     plane_q, plane_d;
    logic [NumLanes-1:0]    rgb_q, rgb_d, rgb_sel;
    logic [RowAddrW-1:0]    row_addr_q, row_addr_d;
    logic                   clk_out_q, clk_out_d;
    logic                   lat_q, lat_d;
    logic                   oe_n_q, oe_n_d;
    logic                   rd_en_q, rd_en_d;
    logic [ROW_W+COL_W-1:0] rd_addr_q, rd_addr_d;
    logic                   frame_done_q, frame_done_d;

    logic                   last_col, last_row, last_plane;
    logic                   tmr_load, tmr_en, tmr_done, tmr_done_next;
    logic [TMR_W-1:0]       tmr_value;

    assign last_col   = (col_q == ColLast);
    assign last_row   = (row_q == RowLast);
    assign last_plane = (plane_q == PlaneLast);

    // Pick the current plane's bit out of each colour lane of the returned word.
    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        logic [BIT_DEPTH-1:0] lane;
        assign lane       = rd_data_in[l*BIT_DEPTH +: BIT_DEPTH];
        assign rgb_sel[l] = lane[plane_q];
    end

    // Display / blanking down-counter.
    hub75_plane_timer #(
        .CntW (TMR_W)
    ) u_timer (
        .clk_i       (clk_in),
        .rst_ni      (rst_n_in),
        .load_i      (tmr_load),
        .value_i     (tmr_value),
        .en_i        (tmr_en),
        .done_o      (tmr_done),
        .done_next_o (tmr_done_next)
    );

    // Timer is armed on the cycle before the phase it measures.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = TMR_W'(BASE_ON) << plane_q;
        tmr_en    = (state_q == StDisplay) || (state_q == StBlank);
        if (state_q == StLatch) begin
            tmr_load = 1'b1;
        end
`ifdef HUB75_DEADTIME_EN
        if ((state_q == StShiftHi) && last_col) begin
            tmr_load  = 1'b1;
            tmr_value = TMR_W'(DEADTIME);
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; enable_in only matters in IDLE and at DISPLAY exit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:      if (enable_in) state_d = StFetchRd;
            StFetchRd:   state_d = StFetchWait;
            StFetchWait: state_d = StShiftLo;
            StShiftLo:   state_d = StShiftHi;
            StShiftHi: begin
                if (last_col) begin
`ifdef HUB75_DEADTIME_EN
                    state_d = StBlank;
`else
                    state_d = StLatch;
`endif
                end else begin
                    state_d = StShiftLo;
                end
            end
            StBlank: begin
`ifdef HUB75_DEADTIME_EN
                if (tmr_done) state_d = StLatch;
`else
                state_d = StIdle;
`endif
            end
            StLatch:     state_d = StDisplay;
            StDisplay:   if (tmr_done) state_d = enable_in ? StFetchRd : StIdle;
            default:     state_d = StIdle;
        endcase
    end

    // Column, row and plane counters plus the pixel shift register.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        plane_d = plane_q;
        rgb_d   = rgb_q;
        if (state_q == StShiftHi) begin
            col_d = last_col ? '0 : col_q + ColOne;
        end
        if ((state_q == StDisplay) && tmr_done) begin
            if (!enable_in) begin
                row_d   = '0;
                plane_d = '0;
            end else if (last_plane) begin
                plane_d = '0;
                row_d   = last_row ? '0 : row_q + RowOne;
            end else begin
                plane_d = plane_q + PlaneOne;
            end
        end
        // After the last column the bits simply hold.
        if ((state_q == StFetchWait) || ((state_q == StShiftHi) && !last_col)) begin
            rgb_d = rgb_sel;
        end
    end

    // Counter and pixel registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            col_q   <= '0;
            row_q   <= '0;
            plane_q <= '0;
            rgb_q   <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            rgb_q   <= rgb_d;
        end
    end

    // FSM outputs, decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        clk_out_d    = (state_d == StShiftHi);
        lat_d        = (state_d == StLatch);
        oe_n_d       = (state_d != StDisplay);
        rd_en_d      = (state_d == StFetchRd) || ((state_d == StShiftLo) && (col_d != ColLast));
        rd_addr_d    = rd_addr_q;
        row_addr_d   = row_addr_q;
        frame_done_d = (state_d == StDisplay) && last_row && last_plane && tmr_done_next;
        if (state_d == StFetchRd) begin
            rd_addr_d = {row_d, {COL_W{1'b0}}};
        end else if (rd_en_d) begin
            // SHIFT_LO prefetches the column after the one being shifted.
            rd_addr_d = {row_q, col_d + ColOne};
        end
`ifdef HUB75_DEADTIME_EN
        if ((state_q == StShiftHi) && (state_d == StBlank)) begin
            row_addr_d = RowAddrW'(row_q);
        end
`else
        if ((state_q == StShiftHi) && (state_d == StLatch)) begin
            row_addr_d = RowAddrW'(row_q);
        end
`endif
    end

    // Output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            clk_out_q    <= 1'b0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            row_addr_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            clk_out_q    <= clk_out_d;
            lat_q        <= lat_d;
            oe_n_q       <= oe_n_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            row_addr_q   <= row_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_en_out   = rd_en_q;
    assign rd_addr_out = rd_addr_q;
    assign R1_data     = rgb_q[LaneR1];
    assign G1_data     = rgb_q[LaneG1];
    assign B1_data     = rgb_q[LaneB1];
    assign R2_data     = rgb_q[LaneR2];
    assign G2_data     = rgb_q[LaneG2];
    assign B2_data     = rgb_q[LaneB2];
    assign A           = row_addr_q[0];
    assign B           = row_addr_q[1];
    assign C           = row_addr_q[2];
    assign D           = row_addr_q[3];
    assign E           = row_addr_q[4];
    assign clk_out     = clk_out_q;
    assign LAT         = lat_q;
    assign OE_N        = oe_n_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// Directed self-checking bench for hub75_scan_scheduler at default parameters.
module tb_hub75_scan_scheduler;

    localparam int W       = 32;
    localparam int ROWS    = 8;
    localparam int BD      = 4;
    localparam int BASE_ON = 8;
`ifdef HUB75_DEADTIME_EN
    localparam int FramePeriod = 3168;
`else
    localparam int FramePeriod = 3104;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [23:0] rd_data = '0;
    logic        R1, G1, B1, R2, G2, B2, A, B, C, D, E;
    logic        clk_out, LAT, OE_N, frame_done;
    logic [5:0]  rgb;
    logic [4:0]  rowa;

    logic [23:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the most recent run_plane call.
    int         pr_lead, pr_rises, pr_chg, pr_on, pr_fd_seen, pr_fd_pos, pr_timeout;
    int         pr_lat_extra;
    logic [4:0] pr_lat_row;
    logic [5:0] pr_lat_rgb;
    logic       pr_lat_oen;
    logic [5:0] cap [0:63];

    assign rgb  = {R1, G1, B1, R2, G2, B2};
    assign rowa = {E, D, C, B, A};

    always #5 clk = ~clk;

    // Framebuffer with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    hub75_scan_scheduler dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .enable_in   (enable),
        .rd_en_out   (rd_en),
        .rd_addr_out (rd_addr),
        .rd_data_in  (rd_data),
        .R1_data     (R1),
        .G1_data     (G1),
        .B1_data     (B1),
        .R2_data     (R2),
        .G2_data     (G2),
        .B2_data     (B2),
        .A           (A),
        .B           (B),
        .C           (C),
        .D           (D),
        .E           (E),
        .clk_out     (clk_out),
        .LAT         (LAT),
        .OE_N        (OE_N),
        .frame_done  (frame_done)
    );

    // Expected {R1,G1,B1,R2,G2,B2} for a pixel on a given plane.
    function automatic logic [5:0] exp_rgb(input int r, input int c, input int p);
        logic [23:0] d;
        d = mem[r * W + c] >> p;
        return {d[20], d[16], d[12], d[8], d[4], d[0]};
    endfunction

    // Observe one row/plane from its FETCH-read cycle through the end of DISPLAY.
    task automatic run_plane(input int drop_at);
        logic       prev_clk;
        logic [5:0] prev_rgb;
        bit         got_lat;
        bit         ended;
        pr_lead = 0; pr_rises = 0; pr_chg = 0; pr_on = 0; pr_fd_seen = 0; pr_fd_pos = 0;
        pr_timeout = 0; pr_lat_extra = 0; pr_lat_row = '0; pr_lat_rgb = '0; pr_lat_oen = 1'b0;
        got_lat = 0;
        ended = 0;
        prev_clk = clk_out;
        prev_rgb = rgb;
        for (int n = 1; n <= 300 && !got_lat; n++) begin
            @(negedge clk);
            if (n == drop_at) enable = 1'b0;
            if (clk_out && !prev_clk) begin
                if (pr_rises == 0) pr_lead = n;
                if (pr_rises < 64) cap[pr_rises] = rgb;
                if (rgb !== prev_rgb) pr_chg++;
                pr_rises++;
            end
            if (frame_done) pr_fd_seen++;
            if (LAT) begin
                got_lat = 1;
                pr_lat_row = rowa;
                pr_lat_rgb = rgb;
                pr_lat_oen = OE_N;
            end
            prev_clk = clk_out;
            prev_rgb = rgb;
        end
        if (got_lat) begin
            for (int n = 0; n < 2000 && !ended; n++) begin
                @(negedge clk);
                if (LAT) pr_lat_extra++;
                if (!OE_N) begin
                    pr_on++;
                    if (frame_done) begin
                        pr_fd_seen++;
                        pr_fd_pos = pr_on;
                    end
                end else begin
                    if (frame_done) pr_fd_seen++;
                    if (pr_on > 0) ended = 1;
                end
            end
        end
        if (!got_lat || !ended) pr_timeout = 1;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({OE_N, LAT, clk_out, rd_en, frame_done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_ctrl {OE_N,LAT,clk_out,rd_en,frame_done}: got %b required 10000",
                     {OE_N, LAT, clk_out, rd_en, frame_done});
        end
        n_checks++;
        if (rd_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rd_addr: got %h required 00", rd_addr);
        end
        n_checks++;
        if (rgb !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_rgb: got %b required 000000", rgb);
        end
        n_checks++;
        if (rowa !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_row_addr: got %b required 00000", rowa);
        end
        rst_n = 1'b1;
        // First edge after release leaves IDLE and issues the column-0 read.
        @(negedge clk);
        n_checks++;
        if ({rd_en, rd_addr} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL first_read {rd_en,rd_addr}: got %b,%h required 1,00", rd_en, rd_addr);
        end
        n_checks++;
        if ({OE_N, clk_out, LAT} !== 3'b100) begin
            n_fail++;
            $display("FAIL first_read_ctrl {OE_N,clk_out,LAT}: got %b required 100",
                     {OE_N, clk_out, LAT});
        end
    endtask

    task automatic test_frame;
        int mism;
        int exp_fd;
        for (int r = 0; r < ROWS; r++) begin
            for (int p = 0; p < BD; p++) begin
                run_plane(0);
                n_checks++;
                if (pr_timeout != 0) begin
                    n_fail++;
                    $display("FAIL plane_timeout r%0d p%0d: got timeout required LAT+DISPLAY", r, p);
                end
                n_checks++;
                if (pr_lead !== 3) begin
                    n_fail++;
                    $display("FAIL first_rise r%0d p%0d: got %0d cycles required 3", r, p, pr_lead);
                end
                n_checks++;
                if (pr_rises !== W) begin
                    n_fail++;
                    $display("FAIL rises r%0d p%0d: got %0d required %0d", r, p, pr_rises, W);
                end
                n_checks++;
                if (pr_chg !== 0) begin
                    n_fail++;
                    $display("FAIL data_stable r%0d p%0d: got %0d changes required 0", r, p, pr_chg);
                end
                mism = 0;
                for (int k = 0; k < W; k++) begin
                    if (cap[k] !== exp_rgb(r, k, p)) mism++;
                end
                n_checks++;
                if (mism !== 0) begin
                    n_fail++;
                    $display("FAIL pixels r%0d p%0d: got %0d bad columns required 0", r, p, mism);
                end
                if (r == 0) begin
                    n_checks++;
                    if (cap[0][5] !== ((p == 0) || (p == 2))) begin
                        n_fail++;
                        $display("FAIL top_r1 p%0d: got %b required %b", p, cap[0][5],
                                 (p == 0) || (p == 2));
                    end
                end
                n_checks++;
                if (pr_lat_row !== 5'(r)) begin
                    n_fail++;
                    $display("FAIL row_addr r%0d p%0d: got %0d required %0d", r, p, pr_lat_row, r);
                end
                n_checks++;
                if (pr_lat_rgb !== exp_rgb(r, W - 1, p)) begin
                    n_fail++;
                    $display("FAIL rgb_hold r%0d p%0d: got %b required %b", r, p, pr_lat_rgb,
                             exp_rgb(r, W - 1, p));
                end
                n_checks++;
                if ({pr_lat_oen, 5'(pr_lat_extra)} !== 6'b100000) begin
                    n_fail++;
                    $display("FAIL latch r%0d p%0d: got OE_N=%b extra=%0d required 1,0", r, p,
                             pr_lat_oen, pr_lat_extra);
                end
                n_checks++;
                if (pr_on !== (BASE_ON << p)) begin
                    n_fail++;
                    $display("FAIL on_time r%0d p%0d: got %0d required %0d", r, p, pr_on,
                             BASE_ON << p);
                end
                exp_fd = ((r == ROWS - 1) && (p == BD - 1)) ? 1 : 0;
                n_checks++;
                if (pr_fd_seen !== exp_fd) begin
                    n_fail++;
                    $display("FAIL frame_done_cnt r%0d p%0d: got %0d required %0d", r, p,
                             pr_fd_seen, exp_fd);
                end
                if (exp_fd == 1) begin
                    n_checks++;
                    if (pr_fd_pos !== (BASE_ON << p)) begin
                        n_fail++;
                        $display("FAIL frame_done_pos: got cycle %0d required %0d", pr_fd_pos,
                                 BASE_ON << p);
                    end
                end
            end
        end
    endtask

    task automatic test_free_run;
        int t_first;
        int period;
        int lats;
        int fds;
        t_first = -1;
        period  = -1;
        lats    = 0;
        fds     = 0;
        for (int n = 0; n < 8000 && period < 0; n++) begin
            @(negedge clk);
            if (t_first >= 0 && LAT) lats++;
            if (frame_done) begin
                fds++;
                if (t_first < 0) t_first = n;
                else period = n - t_first;
            end
        end
        n_checks++;
        if (period !== FramePeriod) begin
            n_fail++;
            $display("FAIL frame_period: got %0d required %0d", period, FramePeriod);
        end
        n_checks++;
        if (lats !== ROWS * BD) begin
            n_fail++;
            $display("FAIL lat_per_frame: got %0d required %0d", lats, ROWS * BD);
        end
        n_checks++;
        if (fds !== 2) begin
            n_fail++;
            $display("FAIL frame_done_width: got %0d pulse cycles required 2", fds);
        end
    endtask

    task automatic test_enable_drop;
        int bad;
        @(negedge clk);
        n_checks++;
        if ({rd_en, rd_addr} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL frame_wrap {rd_en,rd_addr}: got %b,%h required 1,00", rd_en, rd_addr);
        end
        repeat (BD + 1) run_plane(0);  // row 0 all planes, row 1 plane 0
        run_plane(20);                 // drop enable mid-shift of row 1 plane 1
        n_checks++;
        if ({pr_timeout, pr_rises, pr_on} !== {0, W, 2 * BASE_ON}) begin
            n_fail++;
            $display("FAIL drop_completes: got timeout=%0d rises=%0d on=%0d required 0,%0d,%0d",
                     pr_timeout, pr_rises, pr_on, W, 2 * BASE_ON);
        end
        n_checks++;
        if (pr_lat_row !== 5'd1) begin
            n_fail++;
            $display("FAIL drop_row: got %0d required 1", pr_lat_row);
        end
        bad = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rd_en || clk_out || LAT || !OE_N) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL idle_quiet: got %0d active cycles required 0", bad);
        end
        n_checks++;
        if (rowa !== 5'd1) begin
            n_fail++;
            $display("FAIL idle_row_hold: got %0d required 1", rowa);
        end
        enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rd_en, rd_addr} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL restart_read {rd_en,rd_addr}: got %b,%h required 1,00", rd_en, rd_addr);
        end
        run_plane(0);
        n_checks++;
        if ({pr_lat_row, 8'(pr_on), cap[0][5]} !== {5'd0, 8'(BASE_ON), 1'b1}) begin
            n_fail++;
            $display("FAIL restart_plane0: got row=%0d on=%0d R1=%b required 0,%0d,1",
                     pr_lat_row, pr_on, cap[0][5], BASE_ON);
        end
    endtask

    task automatic test_reset_display;
        bit found;
        repeat (BD - 1) run_plane(0);  // finish row 0, now at row 1 plane 0
        found = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            @(negedge clk);
            if (!OE_N) found = 1;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({found, OE_N, rowa} !== {1'b1, 1'b0, 5'd1}) begin
            n_fail++;
            $display("FAIL pre_reset {found,OE_N,row}: got %b,%b,%0d required 1,0,1",
                     found, OE_N, rowa);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({OE_N, LAT, clk_out, rd_en, rowa} !== {4'b1000, 5'd0}) begin
            n_fail++;
            $display("FAIL async_reset {OE_N,LAT,clk_out,rd_en,row}: got %b,%b,%b,%b,%0d required 1,0,0,0,0",
                     OE_N, LAT, clk_out, rd_en, rowa);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rd_en, rd_addr} !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL post_reset_read {rd_en,rd_addr}: got %b,%h required 1,00", rd_en, rd_addr);
        end
        run_plane(0);
        n_checks++;
        if ({pr_lat_row, 8'(pr_on), 8'(pr_rises), 8'(pr_lead)} !==
            {5'd0, 8'(BASE_ON), 8'(W), 8'd3}) begin
            n_fail++;
            $display("FAIL post_reset_plane: got row=%0d on=%0d rises=%0d lead=%0d required 0,%0d,%0d,3",
                     pr_lat_row, pr_on, pr_rises, pr_lead, BASE_ON, W);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0]           = 24'h500000;  // row 0 col 0: R1 = 0101
        mem[1 * W + 31]  = 24'h000008;  // row 1 col 31: B2 = 1000
        mem[2 * W + 7]   = 24'h060000;  // row 2 col 7: G1 = 0110
        mem[7 * W + 0]   = 24'h000F00;  // row 7 col 0: R2 = 1111
        test_reset();
        test_frame();
        test_free_run();
        test_enable_drop();
        test_reset_display();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion required finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hub75_scan_scheduler.md
# hub75_scan_scheduler

Binary-code-modulation scan scheduler for HUB75 LED matrix panels. Sits between the pixel framebuffer and the panel pins, replacing the fixed-pattern screen controller. It reads multi-bit RGB pixels from the framebuffer and sequences the shift, latch and display phases per row and per bit plane. Display time doubles per bit plane to produce grey levels.

## Interface
- SCREEN_WIDTH, 32, columns per row; power of two, ≤64
- SCREEN_DEPTH, 16, total panel rows; scan rows = SCREEN_DEPTH/2, ≤32 scan rows
- BIT_DEPTH, 4, bits per colour channel, 1..8
- BASE_ON, 8, DISPLAY cycles for plane 0; plane b gets BASE_ON<<b
- DEADTIME, 2, blanking cycles; used only with HUB75_DEADTIME_EN
- clk_in  input  1  sole clock, rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- enable_in  input  1  run request
- rd_en_out  output  1  framebuffer read strobe
- rd_addr_out  output  ROW_W+COL_W  {scan row, column}; ROW_W=clog2(SCREEN_DEPTH/2), COL_W=clog2(SCREEN_WIDTH)
- rd_data_in  input  6*BIT_DEPTH  {R1,G1,B1,R2,G2,B2}, each BIT_DEPTH wide, MSB first
- R1_data, G1_data, B1_data, R2_data, G2_data, B2_data  output  1 each  selected plane bit
- A, B, C, D, E  output  1 each  scan row address, zero-extended, E = MSB
- clk_out, LAT, OE_N  output  1 each  panel shift clock, latch, active-low output enable
- frame_done  output  1  one-cycle end-of-frame pulse
- All outputs are registered; clk_out is not a gated clock.

## Operation
- States: IDLE, FETCH (2 cycles), SHIFT_LO, SHIFT_HI, BLANK (macro only), LATCH, DISPLAY.
- Loop order: for row 0..SCREEN_DEPTH/2-1, for plane 0..BIT_DEPTH-1: FETCH → W×(SHIFT_LO, SHIFT_HI) → [BLANK] → LATCH → DISPLAY.
- IDLE → FETCH when enable_in=1. enable_in is sampled only at DISPLAY exit and in IDLE. If it is 0 at DISPLAY exit, go to IDLE; row and plane counters reset to 0.
- Framebuffer read latency is fixed at 1 cycle: rd_data_in is sampled on the edge ending the cycle after rd_en_out.
- FETCH, first cycle: read column 0. Second cycle: no read. RGB output registers load bit `plane` of rd_data_in on FETCH exit.
- SHIFT_LO column c: clk_out=0. If c<W-1, issue a read for column c+1.
- SHIFT_HI: clk_out=1. RGB registers load the next column's bits on exit, unless this is the last column.
- RGB outputs hold their value after the last column.
- LATCH: LAT=1 for 1 cycle. A..E update to the current row on LATCH entry.
- DISPLAY: OE_N=0 for BASE_ON<<plane cycles, counted by a down-counter.
- OE_N=1 in every state except DISPLAY.
- frame_done=1 during the final DISPLAY cycle of the last row, last plane.
- Reset values: state IDLE, row 0, plane 0, column 0, all RGB 0, A..E 0, clk_out 0, LAT 0, OE_N 1, rd_en_out 0, rd_addr_out 0, frame_done 0.
- Reset asserted mid-operation returns every output to these values immediately; no partial latch completes.

## Timing
- Cycles per row/plane without macro: 2 + 2·SCREEN_WIDTH + 1 + BASE_ON<<b.
- Defaults: plane 0 takes 75 cycles; a row takes 388; a frame takes 3104.
- First clk_out rise: 3 cycles after leaving IDLE.
- Pixel data is stable for a full cycle before each clk_out rise and holds through it.
- Counters wrap: column W-1→0, plane BIT_DEPTH-1→0 with row+1, last row→0 with frame_done.

## Configuration
- HUB75_DEADTIME_EN defined: BLANK state of DEADTIME cycles between the last SHIFT_HI and LATCH.
  - OE_N=1 during BLANK; A..E update on BLANK entry instead of LATCH.
  - Defaults add 8 cycles per row, giving 3168 per frame.
- Undefined: no BLANK state; SHIFT_HI → LATCH directly.

## Structure
- Shared package hub75_pkg holds:
  - state enum
  - RGB lane index constants (R1=5 … B2=0)
  - clog2-derived width helpers
- Sub-module hub75_plane_timer: loadable down-counter.
  - Loads BASE_ON<<plane; asserts done on reaching 1.
  - Reused for BLANK with DEADTIME.

## Test plan
- Reset held, then released with enable_in=1 → OE_N=1, LAT=0, all outputs 0 during reset; first rd_en_out with address 0 on the cycle after release plus one.
- Top pixel (row 0, column 0) R=4'b0101, all else 0 → R1_data=1 on the first clock of planes 0 and 2 only; OE_N low for 8 and 32 cycles respectively.
- Free run with defaults → frame_done period 3104 cycles (3168 with HUB75_DEADTIME_EN); LAT pulse count per frame = 32.
- enable_in dropped mid-SHIFT → current row/plane completes through DISPLAY, then IDLE with OE_N=1; re-enable restarts at row 0, plane 0.
- Stall check → exactly 32 clk_out rises between consecutive LAT pulses; data never changes on a clk_out rising cycle.
- Reset asserted during DISPLAY → OE_N=1 and A..E=0 asynchronously; after release the sequence restarts from row 0.
